decoder_3x8: RTL and testbench

DECODER_3X8 -- requirements
Module: decoder_3x8

---
 rtl/decoder_3x8.sv | 60 ++++++
 tb/tb_decoder_3x8.sv | 126 ++++++++++++
 2 files changed

// File: rtl/decoder_3x8.sv
// decoder_3x8: registered 1-to-8 demultiplexer of din onto lanes a..h.
// Ports: clk, rst (sync, active-high), din[WIDTH], in[3] lane select,
//        en (active-low), a..h[WIDTH] lanes, vld.
// Build option: DECODER_3X8_HOLD_EN makes en=1 hold the lanes instead of clearing them.
module decoder_3x8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic [2:0]       in,
  input  logic             en,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic             vld
);

  logic [WIDTH-1:0] lane [8];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 8; i++) begin
        lane[i] <= '0;
      end
      vld <= 1'b0;
    end else if (!en) begin
      for (int unsigned i = 0; i < 8; i++) begin
        lane[i] <= (in == 3'(i)) ? din : '0;
      end
      vld <= 1'b1;
    end else begin
`ifdef DECODER_3X8_HOLD_EN
      for (int unsigned i = 0; i < 8; i++) begin
        lane[i] <= lane[i];
      end
`else
      for (int unsigned i = 0; i < 8; i++) begin
        lane[i] <= '0;
      end
`endif
      vld <= 1'b0;
    end
  end

  assign a = lane[0];
  assign b = lane[1];
  assign c = lane[2];
  assign d = lane[3];
  assign e = lane[4];
  assign f = lane[5];
  assign g = lane[6];
  assign h = lane[7];

endmodule

// File: tb/tb_decoder_3x8.sv
module tb_decoder_3x8;

  localparam int WIDTH = 8;

  typedef struct {
    logic [8*WIDTH-1:0] lanes;
    logic               vld;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic [2:0]       in;
  logic             en;
  logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
  logic             vld;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  exp_t               sb [$];
  logic [8*WIDTH-1:0] model_lanes = '0;

  always #5 clk = ~clk;

  decoder_3x8 #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .din(din), .in(in), .en(en),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .vld(vld)
  );

  wire [8*WIDTH-1:0] got_lanes = {h, g, f, e, d, c, b, a};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, predict the result, then compare after the edge.
  task automatic step(input logic r, input logic [WIDTH-1:0] dv, input logic [2:0] iv,
                      input logic ev, input string tag);
    exp_t x;
    rst = r; din = dv; in = iv; en = ev;
    if (r) begin
      model_lanes = '0;
      x.vld = 1'b0;
    end else if (!ev) begin
      model_lanes = '0;
      model_lanes[iv*WIDTH +: WIDTH] = dv;
      x.vld = 1'b1;
    end else begin
`ifndef DECODER_3X8_HOLD_EN
      model_lanes = '0;
`endif
      x.vld = 1'b0;
    end
    x.lanes = model_lanes;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      x = sb.pop_front();
      check_eq({tag, "_lanes"}, 64'(got_lanes), 64'(x.lanes));
      check_eq({tag, "_vld"}, 64'(vld), 64'(x.vld));
    end
  endtask

  // Disturb the inputs between edges; outputs must not move.
  task automatic perturb(input string tag);
    logic [8*WIDTH-1:0] held_l;
    logic               held_v;
    held_l = got_lanes;
    held_v = vld;
    din = ~din; in = in + 3'd1; en = ~en; rst = ~rst;
    #2;
    check_eq({tag, "_stable_lanes"}, 64'(got_lanes), 64'(held_l));
    check_eq({tag, "_stable_vld"}, 64'(vld), 64'(held_v));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; din = '0; in = '0; en = 1'b1;
    @(negedge clk);

    step(1'b1, 8'd13, 3'd3, 1'b0, "rst0");
    step(1'b1, 8'd13, 3'd3, 1'b0, "rst1");
    perturb("rst_hold");
    step(1'b0, 8'd13, 3'd3, 1'b0, "rst_exit_d");

    step(1'b0, 8'd13, 3'd1, 1'b0, "pre_dis_b");
    step(1'b0, 8'd13, 3'd0, 1'b1, "disabled");
    step(1'b0, 8'd13, 3'd0, 1'b1, "disabled2");

    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'd13, 3'(i), 1'b0, $sformatf("sweep%0d", i));
    end
    perturb("sweep_hold");

    step(1'b0, 8'hFF, 3'd7, 1'b0, "data_ff");
    step(1'b0, 8'h00, 3'd7, 1'b0, "data_00");

    step(1'b0, 8'd42, 3'd2, 1'b0, "pre_rstpri");
    step(1'b1, 8'd13, 3'd5, 1'b0, "rst_pri");
    step(1'b0, 8'd13, 3'd5, 1'b0, "rst_pri_exit");

    for (int i = 0; i < 40; i++) begin
      step(($urandom_range(0, 9) == 0), 8'($urandom), 3'($urandom), ($urandom_range(0, 3) == 0),
           $sformatf("rnd%0d", i));
      if (i % 10 == 5) perturb($sformatf("rnd_hold%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
